rr_arbiter_4: RTL

Four-requester round-robin arbiter with grant locking and a hold-time limit. It shares one downstream resource between four requesters. It produces a registered one-hot grant and the matching 2-bit encoded grant index, which is the same index coding as the team's 4-to-2 encoder. It sits in front of any shared datapath slot that needs a single owner per cycle.

---
 rtl/rr_arbiter_4.sv | 105 ++++++++++
 1 files changed

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with a registered one-hot grant,
// grant locking while the owner keeps requesting, and a hold-time limit.
module rr_arbiter_4 #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] grant_idx,
  output logic       grant_valid,
  output logic       preempt
);

  typedef enum logic {IDLE, GRANT} state_e;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_e            state_q;
  logic [3:0]        grant_q;
  logic [1:0]        idx_q;
  logic [1:0]        ptr_q;
  logic [HOLD_W-1:0] hold_q;
  logic              preempt_q;

  logic [1:0] nxt;
  logic [3:0] others;
  logic       own_req;
  logic [2:0] idle_pick;
  logic [2:0] rot_pick;

  // Returns {found, index}; lower offsets from start are visited last so they win.
  function automatic logic [2:0] pick(input logic [1:0] start, input logic [3:0] r);
    logic [1:0] j;
    pick = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      j = start + 2'(i);
      if (r[j]) pick = {1'b1, j};
    end
  endfunction

  always_comb begin
    nxt       = idx_q + 2'd1;
    own_req   = req[idx_q];
    others    = req & ~(4'b0001 << idx_q);
    idle_pick = pick(ptr_q, req);
    // Release and forced rotation both search from the slot after the owner,
    // and the owner never takes part in either search.
    rot_pick  = pick(nxt, others);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= 4'b0000;
      idx_q     <= 2'd0;
      ptr_q     <= 2'd0;
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      preempt_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (idle_pick[2]) begin
            state_q <= GRANT;
            grant_q <= 4'b0001 << idle_pick[1:0];
            idx_q   <= idle_pick[1:0];
            hold_q  <= '0;
          end
        end
        GRANT: begin
          if (!own_req) begin
            ptr_q <= nxt;
            if (rot_pick[2]) begin
              grant_q <= 4'b0001 << rot_pick[1:0];
              idx_q   <= rot_pick[1:0];
              hold_q  <= '0;
            end else begin
              state_q <= IDLE;
              grant_q <= 4'b0000;
              idx_q   <= 2'd0;
              hold_q  <= '0;
            end
          end else if (hold_q < HOLD_LAST) begin
            hold_q <= hold_q + 1'b1;
          end else if (|others) begin
            ptr_q     <= nxt;
            grant_q   <= 4'b0001 << rot_pick[1:0];
            idx_q     <= rot_pick[1:0];
            hold_q    <= '0;
            preempt_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = idx_q;
  assign grant_valid = |grant_q;
  assign preempt     = preempt_q;

endmodule
